ifu_prefetch: RTL and testbench

Instruction fetch unit sitting upstream of the IF/ID pipeline register. Generates the fetch PC, issues requests to the instruction ROM over a request/grant/response-valid handshake, and buffers returned words in a small in-order prefetch queue. Delivers one instruction and its address per cycle to IF/ID. Honours the pipeline hold and jump controls from the control unit.

---
 rtl/ifu_prefetch_pkg.sv | 21 ++
 rtl/ifu_fifo.sv | 87 ++++++++
 rtl/ifu_prefetch.sv | 210 +++++++++++++++++++++
 tb/tb_ifu_prefetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_prefetch_pkg
//  Description : Shared definitions for the instruction fetch unit: the NOP
//                encoding presented on an empty queue, the default reset PC
//                and the fetch FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ifu_prefetch_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,    // issuing requests, keeping responses
        ST_DRAIN = 1'b1     // dropping responses that predate a jump
    } ifu_state_e;

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fifo
//  Description : DEPTH x WIDTH synchronous FIFO with flush. Registered write,
//                combinational head read. A push while full is accepted when
//                a pop happens in the same cycle. Flush wins over push/pop.
//  Ports       : clk, rst (async, active-low)
//                flush_i, push_i/wdata_i, pop_i/rdata_o
//                count_o, full_o, empty_o
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];

    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by overflow
            if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid
    always_ff @(posedge clk) begin
        if (w_do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_prefetch
//  Description : Instruction fetch unit. Generates the fetch PC, requests
//                words from the instruction ROM over req/gnt/rvalid and
//                buffers responses in an in-order prefetch queue feeding
//                IF/ID one instruction per cycle. Honours hold and jump.
//  Build macro : IFU_MISALIGN_CHK_EN - when defined, a jump to a target with
//                non-zero [1:0] pulses misalign_o and blocks fetching until
//                the next aligned jump. When undefined, misalign_o is 0 and
//                the target's low two bits are ignored.
//  Ports       : clk, rst (async, active-low)
//                hold_flag_i, jump_flag_i, jump_addr_i   - control unit
//                rom_req_o, rom_addr_o, rom_gnt_i,
//                rom_rvalid_i, rom_rdata_i              - instruction ROM
//                inst_o, inst_addr_o, inst_valid_o      - IF/ID
//                misalign_o                             - misaligned jump
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_flag_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        misalign_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifu_state_e     state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  discard_q, discard_d;
    logic           run_q;          // keeps requests off until the first edge after reset

    // instruction queue {address, word}
    logic [63:0]    w_iq_rdata;
    logic [CW-1:0]  w_iq_count;
    logic           w_iq_full;
    logic           w_iq_empty;
    // issue-address queue; its occupancy is the outstanding request count
    logic [31:0]    w_aq_rdata;
    logic [CW-1:0]  w_aq_count;
    logic           w_aq_full;
    logic           w_aq_empty;

    logic           w_pop;
    logic           w_grant;
    logic           w_rsp_in_fetch;
    logic           w_keep_rsp;
    logic [CW:0]    w_claim;
    logic [31:0]    w_jump_target;
    logic           w_blocked;

    assign w_jump_target = jump_addr_i & 32'hFFFF_FFFC;

    // ------------------------------------------------------------------
    // Misaligned-jump handling
    // ------------------------------------------------------------------
`ifdef IFU_MISALIGN_CHK_EN
    logic blocked_q;
    logic misalign_q;
    logic w_jump_misaligned;

    assign w_jump_misaligned = jump_flag_i && (jump_addr_i[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blocked_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= w_jump_misaligned;
            // every jump re-decides: misaligned blocks, aligned releases
            if (jump_flag_i) begin
                blocked_q <= w_jump_misaligned;
            end
        end
    end

    assign w_blocked  = blocked_q;
    assign misalign_o = misalign_q;
`else
    assign w_blocked  = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request / response handshake
    // ------------------------------------------------------------------
    assign w_pop = inst_valid_o && !hold_flag_i;

    // Slots claimed after this cycle: buffered + in flight, minus the head
    // leaving now. Counting the pop keeps the stream at one word per cycle.
    assign w_claim = {1'b0, w_iq_count} + {1'b0, w_aq_count} - (CW+1)'(w_pop);

    assign rom_req_o = run_q
                    && (state_q == ST_FETCH)
                    && !w_blocked
                    && !jump_flag_i
                    && (w_claim < (CW+1)'(DEPTH))
                    && !w_aq_full
                    && !(w_iq_full && !w_pop);

    assign rom_addr_o = fetch_pc_q;
    assign w_grant    = rom_req_o && rom_gnt_i;

    // A response belongs to a live request only in FETCH; in DRAIN it is stale
    assign w_rsp_in_fetch = rom_rvalid_i && (state_q == ST_FETCH) && !w_aq_empty;
    assign w_keep_rsp     = w_rsp_in_fetch && !jump_flag_i;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;

        if ((state_q == ST_DRAIN) && rom_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        if ((state_q == ST_FETCH) && w_grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if ((state_q == ST_DRAIN) && (discard_d == '0)) begin
            state_d = ST_FETCH;
        end

        if (jump_flag_i) begin
            fetch_pc_d = w_jump_target;
            // In FETCH every in-flight request becomes stale; a response
            // arriving right now is already consumed. In DRAIN the count
            // of stale responses is not changed by another jump.
            if (state_q == ST_FETCH) begin
                discard_d = w_aq_count + CW'(w_grant) - CW'(w_rsp_in_fetch);
            end
            state_d = (discard_d != '0) ? ST_DRAIN : ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            run_q      <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Queues
    // ------------------------------------------------------------------
    ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_addr_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (jump_flag_i),
        .push_i  (w_grant),
        .wdata_i (fetch_pc_q),
        .pop_i   (w_keep_rsp),
        .rdata_o (w_aq_rdata),
        .count_o (w_aq_count),
        .full_o  (w_aq_full),
        .empty_o (w_aq_empty)
    );

    ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_inst_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (jump_flag_i),
        .push_i  (w_keep_rsp),
        .wdata_i ({w_aq_rdata, rom_rdata_i}),
        .pop_i   (w_pop && !jump_flag_i),
        .rdata_o (w_iq_rdata),
        .count_o (w_iq_count),
        .full_o  (w_iq_full),
        .empty_o (w_iq_empty)
    );

    assign inst_valid_o = !w_iq_empty;
    assign inst_o       = inst_valid_o ? w_iq_rdata[31:0]  : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? w_iq_rdata[63:32] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_prefetch
//  Description : Self-checking bench for ifu_prefetch. A ROM model answers
//                granted requests in order with data = addr ^ A5A5A5A5; a
//                stream model tracks the next address IF/ID must see and the
//                next address the ROM must be asked for.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifu_prefetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold_flag = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_gnt = 1'b0;
    logic        rom_rvalid = 1'b0;
    logic [31:0] rom_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic        misalign;

    ifu_prefetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .hold_flag_i  (hold_flag),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .rom_req_o    (rom_req),
        .rom_addr_o   (rom_addr),
        .rom_gnt_i    (rom_gnt),
        .rom_rvalid_i (rom_rvalid),
        .rom_rdata_i  (rom_rdata),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_valid_o (inst_valid),
        .misalign_o   (misalign)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int cyc; } rom_req_t;
    rom_req_t    rom_q[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    logic        rst_lvl = 1'b0;

    // stream model
    logic [31:0] exp_pc;        // next address IF/ID must receive
    logic [31:0] issue_pc;      // next address the ROM must be asked for
    logic        blocked;
    logic        exp_mis;
    logic        prev_hold_valid;
    logic [31:0] prev_addr, prev_inst;
    int          idle;

    // last-sample snapshot for directed checks
    logic        s_req, s_valid, s_mis;
    logic [31:0] s_rom_addr, s_iaddr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        exp_pc          = RESET_PC;
        issue_pc        = RESET_PC;
        blocked         = 1'b0;
        exp_mis         = 1'b0;
        prev_hold_valid = 1'b0;
        idle            = 0;
        rom_q.delete();
    endtask

    task automatic sample();
        logic     pop;
        logic     mis;
        rom_req_t r;
        s_req = rom_req; s_valid = inst_valid; s_mis = misalign;
        s_rom_addr = rom_addr; s_iaddr = inst_addr;

        if (!rst_n) begin
            check("rst_req",       {31'b0, rom_req},    32'd0);
            check("rst_valid",     {31'b0, inst_valid}, 32'd0);
            check("rst_inst",      inst,                NOP);
            check("rst_inst_addr", inst_addr,           32'h0);
            check("rst_rom_addr",  rom_addr,            RESET_PC);
            check("rst_misalign",  {31'b0, misalign},   32'd0);
            model_reset();
            return;
        end

        if (!inst_valid) begin
            check("idle_inst_nop",  inst,      NOP);
            check("idle_inst_addr", inst_addr, 32'h0);
        end
        check("misalign", {31'b0, misalign}, {31'b0, exp_mis});
        if (prev_hold_valid) begin
            check("hold_valid", {31'b0, inst_valid}, 32'd1);
            check("hold_addr",  inst_addr, prev_addr);
            check("hold_inst",  inst,      prev_inst);
        end
        if (jump_flag) check("req_in_jump", {31'b0, rom_req}, 32'd0);
        if (blocked)   check("req_blocked", {31'b0, rom_req}, 32'd0);
        if (rom_req)   check("rom_addr",    rom_addr, issue_pc);

        pop = inst_valid && !hold_flag && !jump_flag;
        if (pop) begin
            check("inst_addr", inst_addr, exp_pc);
            check("inst_data", inst,      exp_pc ^ KEY);
        end

        if (!hold_flag && !blocked && !pop) idle++;
        else idle = 0;
        if (idle >= 80) begin
            check("no_progress", idle, 0);
            idle = 0;
        end

        prev_hold_valid = inst_valid && hold_flag && !jump_flag;
        prev_addr = inst_addr;
        prev_inst = inst;
        exp_mis   = 1'b0;

        if (jump_flag) begin
            exp_pc   = jump_addr & 32'hFFFF_FFFC;
            issue_pc = jump_addr & 32'hFFFF_FFFC;
            idle     = 0;
`ifdef IFU_MISALIGN_CHK_EN
            mis     = (jump_addr[1:0] != 2'b00);
            blocked = mis;
            exp_mis = mis;
`else
            mis = 1'b0;
`endif
        end else begin
            mis = 1'b0;
            if (pop) exp_pc = exp_pc + 32'd4;
            if (rom_req && rom_gnt) issue_pc = issue_pc + 32'd4;
        end

        // ROM: the response delivered this cycle leaves, a new grant joins
        if (rom_rvalid) void'(rom_q.pop_front());
        if (rom_req && rom_gnt) begin
            r.addr = rom_addr;
            r.cyc  = cyc_n;
            rom_q.push_back(r);
        end

        // words requested since the last redirect but not yet consumed
        check("occupancy", {31'b0, ((issue_pc - exp_pc) >> 2) <= DEPTH}, 32'd1);
    endtask

    task automatic cycle(input logic hold, input logic jump, input logic [31:0] jaddr,
                         input int gnt_pct, input int rv_pct);
        @(negedge clk);
        rst_n     = rst_lvl;
        hold_flag = hold;
        jump_flag = jump;
        jump_addr = jaddr;
        rom_gnt   = ($urandom_range(99) < gnt_pct);
        if (rst_lvl && rom_q.size() > 0 && rom_q[0].cyc < cyc_n
            && $urandom_range(99) < rv_pct) begin
            rom_rvalid = 1'b1;
            rom_rdata  = rom_q[0].addr ^ KEY;
        end else begin
            rom_rvalid = 1'b0;
            rom_rdata  = $urandom;
        end
        #1;
        sample();
        cyc_n++;
    endtask

    task automatic do_reset(input int n);
        rst_lvl = 1'b0;
        repeat (n) cycle(1'b0, 1'b0, 32'h0, 100, 100);
        rst_lvl = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 100, 100);
        check("req_release_cycle", {31'b0, s_req}, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 100, 100);
        check("first_req",  {31'b0, s_req}, 32'd1);
        check("first_addr", s_rom_addr,     RESET_PC);
    endtask

    initial begin
        int vcnt;
        int lat;
        logic [31:0] ja;
        model_reset();

        // reset, release and streaming at full rate
        do_reset(3);
        vcnt = 0;
        repeat (18) begin
            cycle(1'b0, 1'b0, 32'h0, 100, 100);
            vcnt += int'(s_valid);
        end
        check("stream_valid_cnt", vcnt, 17);

        // hold with a full queue: no requests, head stable
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 100, 100);
            if (i >= 2) check("hold_no_req", {31'b0, s_req}, 32'd0);
        end
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 100, 100);

        // jump with nothing in flight: first target word after 3 cycles
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 100, 100);
        cycle(1'b1, 1'b1, 32'h100, 100, 100);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 100, 100);
            if (s_valid && lat == 0) begin
                lat = k;
                check("jump_first_addr", s_iaddr, 32'h100);
            end
        end
        check("jump_latency", lat, 3);

        // jump with responses withheld: stale words must be dropped
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 100, 0);
        cycle(1'b0, 1'b1, 32'h200, 100, 0);
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 100, 100);

        // misaligned target
        cycle(1'b0, 1'b1, 32'h102, 100, 100);
        cycle(1'b0, 1'b0, 32'h0, 100, 100);
`ifdef IFU_MISALIGN_CHK_EN
        check("misalign_pulse", {31'b0, s_mis}, 32'd1);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 100, 100);
        check("misalign_one_cycle", {31'b0, s_mis}, 32'd0);
        check("misalign_blocks_req", {31'b0, s_req}, 32'd0);
        cycle(1'b0, 1'b1, 32'h200, 100, 100);
`else
        check("misalign_tied_low", {31'b0, s_mis}, 32'd0);
`endif
        repeat (8) cycle(1'b0, 1'b0, 32'h0, 100, 100);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ja = $urandom & 32'h0000_0FFC;
            if ($urandom_range(99) < 20) ja = ja | 32'($urandom_range(1, 3));
            if ($urandom_range(19) == 0) ja = 32'hFFFF_FFF4;
            cycle($urandom_range(99) < 20, $urandom_range(99) < 3, ja, 70, 60);
        end
        repeat (20) cycle(1'b0, 1'b1, 32'h400, 100, 100);
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 100, 100);

        // reset mid-stream with a full queue
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 100, 100);
        check("pre_reset_valid", {31'b0, s_valid}, 32'd1);
        do_reset(2);
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 100, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
